// File: rtl/hv_ang_val_sample_mc.sv
// hv_ang_val_sample_mc: per-channel settle-delayed analog readback capture with stability
// retry, single-shot/periodic modes, valid pulse and sticky done/error flags.
module hv_ang_val_sample_mc #(
    parameter int CH_NUM    = 2,
    parameter int DW        = 8,
    parameter int CLK_M     = 48,
    parameter int DLY_NS    = 2001,
    parameter int PRD_W     = 16,
    parameter int RETRY_MAX = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CH_NUM-1:0]    i_samp_en,
    input  logic [CH_NUM-1:0]    i_mode,
    input  logic [PRD_W-1:0]     i_prd,
    input  logic [CH_NUM*DW-1:0] i_ana_val,
    input  logic [CH_NUM-1:0]    i_clr,
    output logic [CH_NUM*DW-1:0] o_samp_val,
    output logic [CH_NUM-1:0]    o_samp_vld,
    output logic [CH_NUM-1:0]    o_samp_done,
    output logic [CH_NUM-1:0]    o_samp_err
);
    localparam int SAMP_CYC_NUM = (DLY_NS * CLK_M + 999) / 1000;
    localparam int CNT_W        = $clog2(SAMP_CYC_NUM + 1);
    localparam int RTY_W        = $clog2(RETRY_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMP_CYC_NUM);
    // the check edge falls one cycle before cnt would reach SAMP_CYC_NUM, giving T0+SAMP_CYC_NUM-1 latency
    localparam logic [CNT_W-1:0] CNT_CHK = CNT_W'(SAMP_CYC_NUM - 1);
    localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(RETRY_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, PRD, DONE} state_t;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [RTY_W-1:0] retry_q, retry_d;
        logic [PRD_W-1:0] prd_cnt_q, prd_cnt_d;
        logic             mode_q, mode_d;
        logic [DW-1:0]    prv_q, val_q;
        logic             vld_q, done_q, err_q;
        logic             cap, cap_err, match;
        logic [DW-1:0]    ana;

        assign ana   = i_ana_val[k*DW +: DW];
        assign match = (ana == prv_q);

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            retry_d   = retry_q;
            prd_cnt_d = prd_cnt_q;
            mode_d    = mode_q;
            cap       = 1'b0;
            cap_err   = 1'b0;
            if (state_q != IDLE && !i_samp_en[k]) begin
                state_d = IDLE;
                cnt_d   = '0;
                retry_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_d   = i_samp_en[k] ? CNT_W'(1) : '0;
                        retry_d = '0;
                        state_d = i_samp_en[k] ? WAIT : IDLE;
                        mode_d  = i_samp_en[k] ? i_mode[k] : mode_q;
                    end
                    WAIT: begin
                        if (cnt_q < CNT_CHK) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else if (match || retry_q == RTY_LIM) begin
                            cap       = 1'b1;
                            cap_err   = !match;
                            retry_d   = '0;
                            state_d   = mode_q ? PRD : DONE;
                            prd_cnt_d = mode_q ? ((i_prd == '0) ? PRD_W'(1) : i_prd) : prd_cnt_q;
                        end else begin
                            retry_d = retry_q + RTY_W'(1);
                        end
                    end
                    PRD: begin
                        prd_cnt_d = prd_cnt_q - PRD_W'(1);
                        state_d   = (prd_cnt_q <= PRD_W'(1)) ? WAIT : PRD;
                        cnt_d     = (prd_cnt_q <= PRD_W'(1)) ? CNT_MAX : cnt_q;
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                retry_q   <= '0;
                prd_cnt_q <= '0;
                mode_q    <= 1'b0;
                prv_q     <= '0;
                val_q     <= '0;
                vld_q     <= 1'b0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                retry_q   <= retry_d;
                prd_cnt_q <= prd_cnt_d;
                mode_q    <= mode_d;
                prv_q     <= ana;
                val_q     <= cap ? ana : val_q;
                vld_q     <= cap;
                done_q    <= cap | (done_q & ~i_clr[k]);
                err_q     <= (cap & cap_err) | (err_q & ~i_clr[k]);
            end
        end

        assign o_samp_val[k*DW +: DW] = val_q;
        assign o_samp_vld[k]          = vld_q;
        assign o_samp_done[k]         = done_q;
        assign o_samp_err[k]          = err_q;
    end
endmodule

// File: tb/tb_hv_ang_val_sample_mc.sv
// tb_hv_ang_val_sample_mc: directed checks of capture latency, retry, periodic spacing,
// sticky flags, enable abort and reset abort.
module tb_hv_ang_val_sample_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en = '0, mode = '0, clr = '0;
    logic [15:0] prd = '0;
    logic [15:0] ana = '0;
    logic [15:0] val;
    logic [1:0]  vld, done, err;
    int tests = 0, fails = 0;
    int first, ncap, first1, cnt_v, k;
    int exp_edges [6] = '{96, 107, 118, 129, 131, 133};

    hv_ang_val_sample_mc #(.CH_NUM(2), .DW(8), .CLK_M(48), .DLY_NS(2001), .PRD_W(16), .RETRY_MAX(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_samp_en(en), .i_mode(mode), .i_prd(prd), .i_ana_val(ana),
        .i_clr(clr), .o_samp_val(val), .o_samp_vld(vld), .o_samp_done(done), .o_samp_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int m);
        case (p)
            0: return 8'hA5;
            1: return (m < 96) ? ((m % 2 == 1) ? 8'h22 : 8'h11) : (m == 96) ? 8'h11 : 8'h33;
            2: return (m % 2 == 1) ? 8'h55 : 8'hAA;
            default: return 8'h77;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // m counts edges from T0, the first edge that samples en high
    task automatic run_ch(input int ch, input int p, input int n, input int clr_at,
                          output int f, output int nc);
        f = -1;
        nc = 0;
        ana[ch*8 +: 8] = pat(p, 0);
        en[ch] = 1'b1;
        for (int m = 0; m < n; m++) begin
            cyc();
            if (vld[ch] === 1'b1) begin
                if (f < 0) f = m;
                nc++;
            end
            clr[ch] = (m + 1 == clr_at);
            ana[ch*8 +: 8] = pat(p, m + 1);
        end
        clr[ch] = 1'b0;
    endtask

    task automatic stop_ch(input int ch);
        en[ch] = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_val", 32'(val), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);

        run_ch(0, 0, 100, -1, first, ncap);
        chk("t1_edge", first, 96);
        chk("t1_ncap", ncap, 1);
        chk("t1_val0", 32'(val[7:0]), 32'hA5);
        chk("t1_done0", 32'(done[0]), 1);
        chk("t1_err0", 32'(err[0]), 0);
        chk("t1_ch1", {15'd0, done[1], err[1], vld[1], val[15:8]}, 0);
        stop_ch(0);

        run_ch(0, 1, 102, -1, first, ncap);
        chk("t2_edge", first, 98);
        chk("t2_val0", 32'(val[7:0]), 32'h33);
        chk("t2_err0", 32'(err[0]), 0);
        stop_ch(0);

        run_ch(0, 2, 102, -1, first, ncap);
        chk("t3_edge", first, 99);
        chk("t3_val0", 32'(val[7:0]), 32'h55);
        chk("t3_err0", 32'(err[0]), 1);
        chk("t3_done0", 32'(done[0]), 1);
        clr[0] = 1'b1;
        cyc();
        clr[0] = 1'b0;
        chk("t3_clr_done", 32'(done[0]), 0);
        chk("t3_clr_err", 32'(err[0]), 0);
        stop_ch(0);

        run_ch(0, 0, 98, 96, first, ncap);
        chk("t3b_edge", first, 96);
        chk("t3b_done", 32'(done[0]), 1);
        chk("t3b_err", 32'(err[0]), 0);
        stop_ch(0);

        mode = 2'b10;
        prd = 16'd10;
        ana[15:8] = 8'h40;
        en[1] = 1'b1;
        k = 0;
        for (int m = 0; m < 135; m++) begin
            cyc();
            if (vld[1] === 1'b1) begin
                if (k < 6) begin
                    chk("t4_edge", m, exp_edges[k]);
                    chk("t4_val", 32'(val[15:8]), 32'h40 + k);
                end
                k++;
                ana[15:8] = ana[15:8] + 8'd1;
                if (k == 3) prd = 16'd0;
            end
        end
        chk("t4_count", k, 6);
        stop_ch(1);
        mode = 2'b00;

        run_ch(0, 3, 50, -1, first, ncap);
        chk("t5_nocap", ncap, 0);
        en[0] = 1'b0;
        cnt_v = 0;
        for (int m = 0; m < 60; m++) begin
            cyc();
            if (vld[0] === 1'b1) cnt_v++;
        end
        chk("t5_novld", cnt_v, 0);
        chk("t5_hold", 32'(val[7:0]), 32'hA5);
        run_ch(0, 3, 98, -1, first, ncap);
        chk("t5_edge", first, 96);
        chk("t5_val0", 32'(val[7:0]), 32'h77);

        ana = 16'h3412;
        en = 2'b11;
        for (int m = 0; m < 40; m++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_val", 32'(val), 0);
        chk("t6_vld", 32'(vld), 0);
        chk("t6_flags", {30'd0, done} | {28'd0, err, 2'b00}, 0);
        first = -1;
        first1 = -1;
        for (int m = 0; m < 100; m++) begin
            cyc();
            if (vld[0] === 1'b1 && first < 0) first = m;
            if (vld[1] === 1'b1 && first1 < 0) first1 = m;
        end
        chk("t6_edge0", first, 96);
        chk("t6_edge1", first1, 96);
        chk("t6_vals", 32'(val), 32'h3412);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
